uart_stream_ctrl: RTL and testbench

Byte-level traffic controller between the fast_8N1 UART receiver and transmitter.
- Generates periodic ASCII bursts: MSG_LEN incrementing characters from BASE_CHAR, then TERM_CHAR, separated by a programmable idle gap.
- Optionally echoes received bytes back on the transmit line.
- Both sources feed a shared TX FIFO. Received command bytes toggle run and echo modes at runtime.
- The last received byte is exported for the debug LED bar.

---
 rtl/uart_stream_ctrl.sv | 156 +++++++++++++++
 tb/tb_uart_stream_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_stream_ctrl.sv
// UART byte traffic controller: burst generator and RX echo
// sharing one TX FIFO, with runtime run/echo command bytes.
module uart_stream_ctrl #(
  parameter int             GAP_CYCLES = 65536,
  parameter int             MSG_LEN    = 31,
  parameter logic [7:0]     BASE_CHAR  = 8'h41,
  parameter logic [7:0]     TERM_CHAR  = 8'h0A,
  parameter int             FIFO_DEPTH = 16,
  parameter logic [7:0]     CMD_RUN    = 8'h53,
  parameter logic [7:0]     CMD_ECHO   = 8'h45
) (
  input  logic                          sys_clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_strobe,
  input  logic                          load_ok,
  output logic                          tx_load,
  output logic [7:0]                    tx_data,
  output logic [7:0]                    dbg_byte,
  output logic                          run,
  output logic                          echo,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(GAP_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    BURST,
    TERM
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [7:0]      idx;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic       rx_ok;
  logic       is_cmd;
  logic       echo_req;
  logic       full;
  logic       empty;
  logic       pop;
  logic       can_push;
  logic       gen_push;
  logic       echo_push;
  logic       push;
  logic [7:0] push_data;

  always_comb begin
    rx_ok     = en & rx_strobe;
    is_cmd    = (rx_data == CMD_RUN) || (rx_data == CMD_ECHO);
    echo_req  = rx_ok & echo & ~is_cmd;
    full      = fifo_level == (AW+1)'(FIFO_DEPTH);
    empty     = fifo_level == '0;
    pop       = en & ~empty & load_ok & ~tx_load;
    // A pop on the same edge frees the slot a full FIFO needs.
    can_push  = ~full | pop;
    echo_push = echo_req & can_push;
    gen_push  = en & ((state == BURST) || (state == TERM))
              & ~echo_req & can_push;
    push      = echo_push | gen_push;
    push_data = TERM_CHAR;
    if (echo_push)
      push_data = rx_data;
    else if (state == BURST)
      push_data = BASE_CHAR + idx;
  end

  always_ff @(posedge sys_clk) begin
    if (push)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      tx_load    <= 1'b0;
      tx_data    <= '0;
      dbg_byte   <= '0;
      run        <= 1'b0;
      echo       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      tx_load <= pop;
      if (pop) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (push && !pop)
        fifo_level <= fifo_level + 1'b1;
      else if (pop && !push)
        fifo_level <= fifo_level - 1'b1;

      if (rx_ok) begin
        dbg_byte <= rx_data;
        if (rx_data == CMD_RUN)
          run <= ~run;
        if (rx_data == CMD_ECHO)
          echo <= ~echo;
        if (echo_req && !can_push)
          overflow <= 1'b1;
      end

      if (en) begin
        unique case (state)
          IDLE: begin
            cnt <= '0;
            if (run)
              state <= GAP;
          end
          GAP: begin
            if (!run) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == CW'(GAP_CYCLES - 1)) begin
              state <= BURST;
              idx   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          BURST: begin
            if (gen_push) begin
              if (idx == 8'(MSG_LEN - 1))
                state <= TERM;
              else
                idx <= idx + 1'b1;
            end
          end
          TERM: begin
            if (gen_push) begin
              state <= run ? GAP : IDLE;
              cnt   <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_stream_ctrl.sv
// Directed bench for uart_stream_ctrl: bursts, echo,
// overflow, wrap-around, run stop, enable hold and reset.
module tb_uart_stream_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en;
  logic       load_ok;

  logic [7:0] a_rx_data;
  logic       a_rx_strobe;
  logic       a_tx_load;
  logic [7:0] a_tx_data;
  logic [7:0] a_dbg;
  logic       a_run;
  logic       a_echo;
  logic       a_ovf;
  logic [2:0] a_level;

  logic [7:0] b_rx_data;
  logic       b_rx_strobe;
  logic       b_tx_load;
  logic [7:0] b_tx_data;
  logic [7:0] b_dbg;
  logic       b_run;
  logic       b_echo;
  logic       b_ovf;
  logic [4:0] b_level;

  uart_stream_ctrl #(
    .GAP_CYCLES(8),
    .MSG_LEN(3),
    .FIFO_DEPTH(4)
  ) u_a (
    .sys_clk(clk),
    .rst_n(rst_n),
    .en(en),
    .rx_data(a_rx_data),
    .rx_strobe(a_rx_strobe),
    .load_ok(load_ok),
    .tx_load(a_tx_load),
    .tx_data(a_tx_data),
    .dbg_byte(a_dbg),
    .run(a_run),
    .echo(a_echo),
    .overflow(a_ovf),
    .fifo_level(a_level)
  );

  uart_stream_ctrl #(
    .GAP_CYCLES(4),
    .MSG_LEN(4),
    .BASE_CHAR(8'hFE),
    .FIFO_DEPTH(16)
  ) u_b (
    .sys_clk(clk),
    .rst_n(rst_n),
    .en(en),
    .rx_data(b_rx_data),
    .rx_strobe(b_rx_strobe),
    .load_ok(load_ok),
    .tx_load(b_tx_load),
    .tx_data(b_tx_data),
    .dbg_byte(b_dbg),
    .run(b_run),
    .echo(b_echo),
    .overflow(b_ovf),
    .fifo_level(b_level)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int viol = 0;
  int run_cyc = -1;
  logic a_prev = 1'b0;
  logic b_prev = 1'b0;
  logic [7:0] qa[$];
  int         qa_cyc[$];
  logic [7:0] qb[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_tx_load) begin
      qa.push_back(a_tx_data);
      qa_cyc.push_back(cyc);
    end
    if (b_tx_load)
      qb.push_back(b_tx_data);
    if ((a_tx_load && a_prev) || (b_tx_load && b_prev))
      viol++;
    a_prev = a_tx_load;
    b_prev = b_tx_load;
    if (a_run && run_cyc < 0)
      run_cyc = cyc;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int qa_at(input int i);
    return (i < qa.size()) ? int'(qa[i]) : -1;
  endfunction

  function automatic int qb_at(input int i);
    return (i < qb.size()) ? int'(qb[i]) : -1;
  endfunction

  task automatic send_a(input logic [7:0] b);
    @(posedge clk);
    #1;
    a_rx_data   = b;
    a_rx_strobe = 1'b1;
    @(posedge clk);
    #1;
    a_rx_strobe = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    @(posedge clk);
    #1;
    b_rx_data   = b;
    b_rx_strobe = 1'b1;
    @(posedge clk);
    #1;
    b_rx_strobe = 1'b0;
  endtask

  task automatic wait_qa(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (qa.size() >= n)
        break;
    end
  endtask

  initial begin
    logic [7:0] burst1 [4];
    logic [7:0] wrapseq [5];
    logic [7:0] fifo_in [4];
    bit hit;
    burst1  = '{8'h41, 8'h42, 8'h43, 8'h0A};
    wrapseq = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h0A};
    fifo_in = '{8'h11, 8'h22, 8'h33, 8'h44};

    rst_n       = 1'b0;
    en          = 1'b1;
    load_ok     = 1'b1;
    a_rx_data   = '0;
    a_rx_strobe = 1'b0;
    b_rx_data   = '0;
    b_rx_strobe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_load", a_tx_load, 0);
    chk("rst_tx_data", a_tx_data, 0);
    chk("rst_level", a_level, 0);
    chk("rst_run", a_run, 0);
    chk("rst_echo", a_echo, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_dbg", a_dbg, 0);
    rst_n = 1'b1;

    // wrap-around burst on the second instance
    send_b(8'h53);
    chk("t4_run", b_run, 1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (qb.size() >= 5)
        break;
    end
    for (int i = 0; i < 5; i++)
      chk($sformatf("t4_byte%0d", i), qb_at(i), wrapseq[i]);
    send_b(8'h53);

    // periodic bursts
    send_a(8'h53);
    chk("t1_run", a_run, 1);
    wait_qa(8, 200);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t1_byte%0d", i), qa_at(i), burst1[i % 4]);
    chk("t1_first_lat", (qa_cyc.size() > 0) ? qa_cyc[0] - run_cyc : -1, 11);
    chk("t1_gap", (qa_cyc.size() > 4) ? qa_cyc[4] - qa_cyc[3] : -1, 6);

    // stop run mid-burst
    wait_qa(9, 200);
    chk("t5_start", qa_at(8), 8'h41);
    send_a(8'h53);
    chk("t5_run_off", a_run, 0);
    repeat (60) @(negedge clk);
    chk("t5_count", qa.size(), 12);
    chk("t5_b9", qa_at(9), 8'h42);
    chk("t5_b10", qa_at(10), 8'h43);
    chk("t5_b11", qa_at(11), 8'h0A);

    // echo path
    send_a(8'h45);
    chk("t2_echo", a_echo, 1);
    send_a(8'h7A);
    chk("t2_dbg", a_dbg, 8'h7A);
    repeat (6) @(negedge clk);
    chk("t2_count", qa.size(), 13);
    chk("t2_byte", qa_at(12), 8'h7A);
    send_a(8'h53);
    send_a(8'h53);
    send_a(8'h45);
    send_a(8'h45);
    repeat (20) @(negedge clk);
    chk("t2_cmd_noecho", qa.size(), 13);
    chk("t2_echo_kept", a_echo, 1);
    chk("t2_run_kept", a_run, 0);
    chk("t2_dbg_cmd", a_dbg, 8'h45);

    // overflow on a full FIFO
    load_ok = 1'b0;
    send_a(8'h11);
    send_a(8'h22);
    send_a(8'h33);
    send_a(8'h44);
    chk("t3_ovf_pre", a_ovf, 0);
    send_a(8'h55);
    chk("t3_level", a_level, 4);
    chk("t3_ovf", a_ovf, 1);
    load_ok = 1'b1;
    repeat (20) @(negedge clk);
    chk("t3_count", qa.size(), 17);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_byte%0d", i), qa_at(13 + i), fifo_in[i]);
    chk("t3_drained", a_level, 0);
    chk("t3_ovf_sticky", a_ovf, 1);

    // enable low holds everything
    load_ok = 1'b0;
    send_a(8'h66);
    send_a(8'h77);
    @(posedge clk);
    #1;
    en      = 1'b0;
    load_ok = 1'b1;
    send_a(8'h88);
    repeat (10) @(negedge clk);
    chk("en_level", a_level, 2);
    chk("en_noload", qa.size(), 17);
    chk("en_dbg", a_dbg, 8'h77);
    @(posedge clk);
    #1;
    en = 1'b1;
    repeat (10) @(negedge clk);
    chk("en_count", qa.size(), 19);
    chk("en_b0", qa_at(17), 8'h66);
    chk("en_b1", qa_at(18), 8'h77);

    // reset mid-burst
    load_ok = 1'b0;
    send_a(8'h53);
    hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (a_level == 3) begin
        hit   = 1'b1;
        rst_n = 1'b0;
        break;
      end
    end
    chk("t6_reached3", hit, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t6_level", a_level, 0);
    chk("t6_run", a_run, 0);
    chk("t6_echo", a_echo, 0);
    chk("t6_ovf", a_ovf, 0);
    chk("t6_dbg", a_dbg, 0);
    chk("t6_tx_load", a_tx_load, 0);
    load_ok = 1'b1;
    repeat (40) @(negedge clk);
    chk("t6_quiet", qa.size(), 19);

    chk("load_spacing", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
